// File: rtl/lsu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl_if
// Description : Data-memory bus bundle between the load/store sequencer
//               (master) and the memory (slave).
//               master drives : mem_req, mem_we, mem_be, mem_addr, mem_wdata
//               slave drives  : mem_gnt, mem_rvalid, mem_rdata
//               req/gnt accepts the command; rvalid completes it, and carries
//               read data for loads.
// Revision    : 1.0  initial release
// ============================================================================
interface lsu_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_be,
        output mem_addr,
        output mem_wdata,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_be,
        input  mem_addr,
        input  mem_wdata,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl
// Description : Load/store sequencer. It takes one memory op from the execute
//               stage, checks alignment, and runs a req/gnt/rvalid
//               transaction with byte-lane enables. It extends load data and
//               holds busy_o until the op completes. A transaction that spends
//               TIMEOUT_CYCLES cycles in REQ+WAIT is aborted with bus_error_o.
// Ports       : clk, reset     - clock, asynchronous active-high reset
//               start_i        - memory op presented (ignored while busy_o)
//               op_i           - 0 LB,1 LBU,2 LH,3 LHU,4 LW,5 SW,6 SH,7 SB
//               address_i      - effective byte address
//               wdata_i        - store data (low byte/half for SB/SH)
//               busy_o         - transaction in flight (pipeline stall)
//               done_o         - one-cycle completion pulse
//               rdata_wb_o     - extended load result
//               we_rb_o        - register-bank write enable (with done_o)
//               misaligned_o   - alignment exception
//               bus_error_o    - timeout abort
//               mem            - data-memory bus (master side)
// Revision    : 1.0  initial release
// ============================================================================
module lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [31:0]       address_i,
    input  logic [31:0]       wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [31:0]       rdata_wb_o,
    output logic              we_rb_o,
    output logic              misaligned_o,
    output logic              bus_error_o,
    lsu_ctrl_if.master        mem
);

    localparam logic [2:0] c_OP_LB  = 3'd0;
    localparam logic [2:0] c_OP_LBU = 3'd1;
    localparam logic [2:0] c_OP_LH  = 3'd2;
    localparam logic [2:0] c_OP_LHU = 3'd3;
    localparam logic [2:0] c_OP_LW  = 3'd4;
    localparam logic [2:0] c_OP_SW  = 3'd5;
    localparam logic [2:0] c_OP_SH  = 3'd6;
    localparam logic [2:0] c_OP_SB  = 3'd7;

    // Counter value seen during the last permitted REQ/WAIT cycle.
    localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q,      state_d;
    logic [2:0]  op_q,         op_d;
    logic [1:0]  lane_q,       lane_d;
    logic        mem_we_q,     mem_we_d;
    logic [3:0]  mem_be_q,     mem_be_d;
    logic [31:0] mem_addr_q,   mem_addr_d;
    logic [31:0] mem_wdata_q,  mem_wdata_d;
    logic [31:0] rdata_wb_q,   rdata_wb_d;
    logic        we_rb_q,      we_rb_d;
    logic        misaligned_q, misaligned_d;
    logic        bus_error_q,  bus_error_d;
    logic [15:0] tmo_cnt_q,    tmo_cnt_d;

    // ---------------------------------------------------------------------
    // Request decode of the incoming op (used only in IDLE)
    // ---------------------------------------------------------------------
    logic        w_is_byte;
    logic        w_is_half;
    logic        w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_lane_mask;
    logic [31:0] w_wdata_lanes;

    assign w_is_byte = (op_i == c_OP_LB) || (op_i == c_OP_LBU) || (op_i == c_OP_SB);
    assign w_is_half = (op_i == c_OP_LH) || (op_i == c_OP_LHU) || (op_i == c_OP_SH);

    assign w_misaligned = w_is_half ? address_i[0]
                        : w_is_byte ? 1'b0
                        : (address_i[1:0] != 2'b00);

    assign w_be = w_is_byte ? (4'b0001 << address_i[1:0])
                : w_is_half ? (4'b0011 << address_i[1:0])
                : 4'b1111;

    assign w_lane_mask   = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
    assign w_wdata_lanes = (wdata_i << {address_i[1:0], 3'b000}) & w_lane_mask;

    // ---------------------------------------------------------------------
    // Load data extraction: move the addressed lane to bit 0, then extend
    // ---------------------------------------------------------------------
    logic [31:0] w_rd_shifted;
    logic [31:0] w_load_ext;

    assign w_rd_shifted = mem.mem_rdata >> {lane_q, 3'b000};

    always_comb begin
        w_load_ext = mem.mem_rdata;
        case (op_q)
            c_OP_LB:  w_load_ext = {{24{w_rd_shifted[7]}},  w_rd_shifted[7:0]};
            c_OP_LBU: w_load_ext = {24'd0,                  w_rd_shifted[7:0]};
            c_OP_LH:  w_load_ext = {{16{w_rd_shifted[15]}}, w_rd_shifted[15:0]};
            c_OP_LHU: w_load_ext = {16'd0,                  w_rd_shifted[15:0]};
            default:  w_load_ext = mem.mem_rdata;
        endcase
    end

    logic w_is_load_q;
    logic w_timeout;

    assign w_is_load_q = (op_q <= c_OP_LW);
    assign w_timeout   = (tmo_cnt_q == c_TIMEOUT_LAST);

    // ---------------------------------------------------------------------
    // Next-state and datapath
    // ---------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        lane_d       = lane_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rdata_wb_d   = rdata_wb_q;
        we_rb_d      = 1'b0;
        misaligned_d = misaligned_q;
        bus_error_d  = bus_error_q;
        tmo_cnt_d    = tmo_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    op_d         = op_i;
                    lane_d       = address_i[1:0];
                    rdata_wb_d   = 32'd0;
                    misaligned_d = 1'b0;
                    bus_error_d  = 1'b0;
                    tmo_cnt_d    = 16'd0;
                    if (w_misaligned) begin
                        misaligned_d = 1'b1;
                        state_d      = S_DONE;
                    end else begin
                        mem_addr_d  = {address_i[31:2], 2'b00};
                        mem_be_d    = w_be;
                        mem_we_d    = (op_i >= c_OP_SW);
                        mem_wdata_d = w_wdata_lanes;
                        state_d     = S_REQ;
                    end
                end
            end

            S_REQ: begin
                tmo_cnt_d = tmo_cnt_q + 16'd1;
                // A response in the grant cycle finishes the op at once; a
                // response before the grant belongs to nobody and is dropped.
                if (mem.mem_gnt && mem.mem_rvalid) begin
                    state_d = S_DONE;
                    if (w_is_load_q) begin
                        rdata_wb_d = w_load_ext;
                        we_rb_d    = 1'b1;
                    end
                end else if (w_timeout) begin
                    state_d     = S_DONE;
                    bus_error_d = 1'b1;
                    rdata_wb_d  = 32'd0;
                end else if (mem.mem_gnt) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                tmo_cnt_d = tmo_cnt_q + 16'd1;
                if (mem.mem_rvalid) begin
                    state_d = S_DONE;
                    if (w_is_load_q) begin
                        rdata_wb_d = w_load_ext;
                        we_rb_d    = 1'b1;
                    end
                end else if (w_timeout) begin
                    state_d     = S_DONE;
                    bus_error_d = 1'b1;
                    rdata_wb_d  = 32'd0;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= 3'd0;
            lane_q       <= 2'd0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'd0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            rdata_wb_q   <= 32'd0;
            we_rb_q      <= 1'b0;
            misaligned_q <= 1'b0;
            bus_error_q  <= 1'b0;
            tmo_cnt_q    <= 16'd0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            lane_q       <= lane_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_wb_q   <= rdata_wb_d;
            we_rb_q      <= we_rb_d;
            misaligned_q <= misaligned_d;
            bus_error_q  <= bus_error_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE);
    assign rdata_wb_o   = rdata_wb_q;
    assign we_rb_o      = we_rb_q;
    assign misaligned_o = misaligned_q;
    assign bus_error_o  = bus_error_q;

    assign mem.mem_req   = (state_q == S_REQ);
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_ctrl
// Description : Self-checking bench for lsu_ctrl. A memory responder with
//               per-transaction grant/response delays drives the bus. Each
//               op's expected cycle-by-cycle behaviour is derived from its
//               size, alignment, response timing and the timeout budget.
// Revision    : 1.0  initial release
// ============================================================================
module tb_lsu_ctrl;

    localparam int TIMEOUT_CYCLES = 4;

    logic        clk;
    logic        reset;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] address_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] rdata_wb_o;
    logic        we_rb_o;
    logic        misaligned_o;
    logic        bus_error_o;

    int n_checks;
    int n_fail;

    lsu_ctrl_if mem_bus ();

    lsu_ctrl #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .op_i         (op_i),
        .address_i    (address_i),
        .wdata_i      (wdata_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .rdata_wb_o   (rdata_wb_o),
        .we_rb_o      (we_rb_o),
        .misaligned_o (misaligned_o),
        .bus_error_o  (bus_error_o),
        .mem          (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference rules ----------------
    function automatic int op_bytes(input logic [2:0] op);
        if (op == 3'd0 || op == 3'd1 || op == 3'd7) return 1;
        if (op == 3'd2 || op == 3'd3 || op == 3'd6) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] size_mask(input int nb);
        if (nb == 4) return 32'hFFFF_FFFF;
        return (32'd1 << (8 * nb)) - 32'd1;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] op, input int lane,
                                             input logic [31:0] rd);
        int          nb;
        logic [31:0] m;
        logic [31:0] v;
        nb = op_bytes(op);
        m  = size_mask(nb);
        v  = (rd >> (8 * lane)) & m;
        if ((op == 3'd0 || op == 3'd2) && v[8 * nb - 1]) v = v | ~m;
        return v;
    endfunction

    // One op, checked every cycle from T+1 to the first idle cycle after done.
    // gd: cycles of grant delay after entering REQ; same: response with grant;
    // otherwise response rd cycles after the grant cycle's successor.
    task automatic run_op(input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input int gd, input int rd,
                          input bit same, input logic [31:0] rdat, input bit noisy);
        int          nb, lane, gc, rc, done_c, req_last;
        bit          mis, ok, is_load;
        logic [31:0] e_be, e_wdata;
        nb      = op_bytes(op);
        lane    = int'(addr[1:0]);
        mis     = (int'(addr % 32'(nb)) != 0);
        is_load = (op <= 3'd4);
        gc      = 1 + gd;
        rc      = same ? gc : gc + 1 + rd;
        ok      = !mis && (rc <= TIMEOUT_CYCLES);
        done_c  = mis ? 1 : (ok ? rc + 1 : TIMEOUT_CYCLES + 1);
        req_last = mis ? 0 : ((gc < TIMEOUT_CYCLES) ? gc : TIMEOUT_CYCLES);
        e_be    = 32'(((1 << nb) - 1) << lane);
        e_wdata = (wd & size_mask(nb)) << (8 * lane);

        start_i   = 1'b1;
        op_i      = op;
        address_i = addr;
        wdata_i   = wd;
        mem_bus.mem_gnt    = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        for (int j = 1; j <= done_c + 1; j++) begin
            @(posedge clk); #1;
            chk_eq("busy", 32'(busy_o), 32'(j <= done_c));
            chk_eq("done", 32'(done_o), 32'(j == done_c));
            chk_eq("mem_req", 32'(mem_bus.mem_req), 32'(j <= req_last));
            if (j <= req_last) begin
                chk_eq("mem_addr", mem_bus.mem_addr, addr & 32'hFFFF_FFFC);
                chk_eq("mem_be", 32'(mem_bus.mem_be), e_be);
                chk_eq("mem_we", 32'(mem_bus.mem_we), 32'(!is_load));
                if (!is_load) chk_eq("mem_wdata", mem_bus.mem_wdata, e_wdata);
            end
            if (j >= done_c) begin
                chk_eq("misaligned", 32'(misaligned_o), 32'(mis));
                chk_eq("bus_error", 32'(bus_error_o), 32'(!mis && !ok));
                chk_eq("we_rb", 32'(we_rb_o), 32'(j == done_c && ok && is_load));
                if (ok && is_load)
                    chk_eq("rdata_wb", rdata_wb_o, exp_load(op, lane, rdat));
                else if (!mis && !ok)
                    chk_eq("rdata_wb_abort", rdata_wb_o, 32'd0);
            end else begin
                chk_eq("we_rb_idle", 32'(we_rb_o), 32'd0);
            end
            // Drive for cycle j: busy-time starts must be ignored.
            if (noisy && j <= done_c) begin
                start_i   = 1'($urandom_range(0, 1));
                op_i      = 3'($urandom);
                address_i = $urandom;
                wdata_i   = $urandom;
            end else begin
                start_i = 1'b0;
            end
            mem_bus.mem_rdata  = rdat;
            mem_bus.mem_gnt    = !mis && (j == gc);
            mem_bus.mem_rvalid = !mis && ((j == rc) ||
                                 (noisy && j < gc && ($urandom_range(0, 1) == 1)));
            if (j == done_c + 1) begin
                mem_bus.mem_gnt    = 1'b0;
                mem_bus.mem_rvalid = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        start_i   = 1'b0;
        op_i      = 3'd0;
        address_i = 32'd0;
        wdata_i   = 32'd0;
        mem_bus.mem_gnt    = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata  = 32'd0;

        #1;
        chk_eq("rst_busy", 32'(busy_o), 32'd0);
        chk_eq("rst_done", 32'(done_o), 32'd0);
        chk_eq("rst_req", 32'(mem_bus.mem_req), 32'd0);
        chk_eq("rst_rdata", rdata_wb_o, 32'd0);
        chk_eq("rst_flags", {29'd0, we_rb_o, misaligned_o, bus_error_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Directed cases
        run_op(3'd0, 32'h0000_0103, 32'd0, 0, 0, 1'b0, 32'h80AA_5500, 1'b0);
        run_op(3'd3, 32'h0000_0202, 32'd0, 3, 0, 1'b1, 32'hBEEF_1234, 1'b0);
        run_op(3'd7, 32'h0000_0001, 32'h1234_5678, 0, 1, 1'b0, 32'hDEAD_BEEF, 1'b1);
        run_op(3'd4, 32'h0000_0006, 32'd0, 0, 0, 1'b0, 32'h1111_1111, 1'b0);
        run_op(3'd6, 32'h0000_0003, 32'hFFFF_FFFF, 0, 0, 1'b0, 32'd0, 1'b0);
        run_op(3'd5, 32'h0000_0010, 32'hA5A5_5A5A, 100, 0, 1'b0, 32'd0, 1'b0);
        // Late responses after the abort must not produce another done.
        for (int k = 0; k < 3; k++) begin
            mem_bus.mem_gnt    = 1'b1;
            mem_bus.mem_rvalid = 1'b1;
            @(posedge clk); #1;
            chk_eq("late_done", 32'(done_o), 32'd0);
            chk_eq("late_busy", 32'(busy_o), 32'd0);
        end
        mem_bus.mem_gnt    = 1'b0;
        mem_bus.mem_rvalid = 1'b0;

        // Reset while waiting for a response
        run_op(3'd2, 32'h0000_0012, 32'd0, 0, 0, 1'b0, 32'h8001_0000, 1'b0);
        start_i   = 1'b1;
        op_i      = 3'd4;
        address_i = 32'h0000_0080;
        @(posedge clk); #1;
        start_i = 1'b0;
        mem_bus.mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_bus.mem_gnt = 1'b0;
        chk_eq("wait_busy", 32'(busy_o), 32'd1);
        reset = 1'b1;
        #1;
        chk_eq("arst_busy", 32'(busy_o), 32'd0);
        chk_eq("arst_done", 32'(done_o), 32'd0);
        chk_eq("arst_rdata", rdata_wb_o, 32'd0);
        chk_eq("arst_flags", {29'd0, we_rb_o, misaligned_o, bus_error_o}, 32'd0);
        chk_eq("arst_req", 32'(mem_bus.mem_req), 32'd0);
        chk_eq("arst_addr", mem_bus.mem_addr, 32'd0);
        chk_eq("arst_be", 32'(mem_bus.mem_be), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        mem_bus.mem_rvalid = 1'b1;
        @(posedge clk); #1;
        mem_bus.mem_rvalid = 1'b0;
        chk_eq("arst_no_done", 32'(done_o), 32'd0);
        run_op(3'd4, 32'h0000_0040, 32'd0, 0, 0, 1'b0, 32'hCAFE_F00D, 1'b0);

        // Randomized ops
        for (int n = 0; n < 300; n++) begin
            run_op(3'($urandom_range(0, 7)), $urandom, $urandom,
                   $urandom_range(0, 2), $urandom_range(0, 2),
                   ($urandom_range(0, 3) == 0), $urandom,
                   1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store sequencer between the execute-stage memory unit and the data-memory bus. It accepts one load/store per transaction and checks alignment. It then drives a req/gnt/rvalid bus handshake with byte-lane enables, sign/zero-extends load data, and stalls the pipeline until completion. It makes the memory path multi-cycle and tolerant of wait states.

Parameters:
TIMEOUT_CYCLES, 255, cycles spent in REQ+WAIT before aborting with bus_error (1..65535)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  execute stage presents a memory op this cycle
op  input  instruction_type  OP0 LB, OP1 LBU, OP2 LH, OP3 LHU, OP4 LW, OP5 SW, OP6 SH, OP7 SB
address  input  32  effective byte address (base+offset)
wdata  input  32  store data (low byte/half used for SB/SH)
busy  output  1  transaction in flight; pipeline stall
done  output  1  one-cycle completion pulse
rdata_wb  output  32  extended load result, valid while done=1
we_rb  output  1  regbank write enable, valid while done=1
misaligned  output  1  alignment exception, valid while done=1
bus_error  output  1  timeout abort, valid while done=1
mem_req  output  1  bus request
mem_we  output  1  1=store, 0=load
mem_be  output  4  byte enables
mem_addr  output  32  word-aligned bus address
mem_wdata  output  32  lane-positioned store data
mem_gnt  input  1  request accepted
mem_rvalid  input  1  response valid (loads and stores)
mem_rdata  input  32  read word

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0. Timeout counter 0. An in-flight transaction is abandoned; no done is produced.
- States: IDLE, REQ, WAIT, DONE. busy = (state != IDLE).
- IDLE with start=1: latch op and address. Check alignment:
  - LH/LHU/SH require address[0]=0.
  - LW/SW require address[1:0]=0.
  - Byte ops are always aligned.
- Misaligned in IDLE: go directly to DONE with misaligned=1 and we_rb=0. No bus activity.
- Aligned in IDLE:
  - mem_addr = {address[31:2],2'b00}.
  - Byte: mem_be = 4'b0001<<address[1:0]. Half: 4'b0011<<address[1:0]. Word: 4'b1111.
  - mem_wdata = wdata shifted left by 8*address[1:0]; zeros outside the enabled lanes.
  - mem_we=1 for OP5..OP7, else 0.
  - Next state REQ.
- REQ: mem_req=1. mem_addr, mem_be, mem_we and mem_wdata are held stable until mem_gnt=1 is sampled.
  - On gnt: mem_req drops the next cycle and the state goes to WAIT.
  - gnt and rvalid in the same cycle: complete directly to DONE.
  - rvalid without gnt: ignored.
- WAIT: mem_req=0. On mem_rvalid go to DONE.
  - Loads: select the lane by address[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through. Register the result into rdata_wb.
- Timeout: the counter clears on leaving IDLE and increments each cycle in REQ/WAIT.
  - On reaching TIMEOUT_CYCLES: go to DONE with bus_error=1, rdata_wb=0, we_rb=0, and mem_req dropped.
  - A late rvalid/gnt arriving after the abort is ignored.
- DONE: done=1 for exactly one cycle. we_rb=1 only for successful loads; stores give we_rb=0. Next state IDLE.
  - rdata_wb, misaligned and bus_error hold until the next transaction's start is accepted.
- start while busy=1 (including the DONE cycle): ignored. The earliest next start is the cycle after done.
- Minimum latency, zero wait states: start at cycle T, REQ at T+1 with gnt, WAIT at T+2 with rvalid, done at T+3. With gnt+rvalid in the same cycle, done at T+2.
- Misaligned latency: done at T+1.

Test Plan:
- LB at address 0x103 with mem_rdata=0x80AA5500 → mem_addr=0x100, mem_be=4'b1000, rdata_wb=0xFFFFFF80, we_rb=1, done at T+3.
- LHU at 0x202 with rdata=0xBEEF1234, gnt delayed 3 cycles → mem_req held 4 cycles with stable outputs, rdata_wb=0x0000BEEF.
- SB at 0x1 with wdata=0x12345678 → mem_we=1, mem_be=4'b0010, mem_wdata=0x00007800, we_rb=0; start during busy ignored.
- LW at 0x6 → no mem_req, done at T+1, misaligned=1, we_rb=0; SH at 0x3 gives the same result.
- TIMEOUT_CYCLES=4, gnt never asserted → done with bus_error=1 after 4 cycles in REQ; a late rvalid afterwards produces no second done.
- reset asserted in WAIT → all outputs 0 immediately; the following LW at 0x40 (rdata=0xCAFEF00D) completes normally with rdata_wb=0xCAFEF00D.
